lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit that sits between the single-cycle core's memory-stage request and the word-only data memory. It is the initiator side of the memory's WE/A/WD/RD interface.
- Supports byte, halfword and word loads with sign or zero extension, and byte/halfword stores via read-modify-write.
- Flags misaligned, illegal-funct3 and out-of-range accesses as errors without touching memory.
- Multi-cycle; the core stalls on req_ready/rsp_valid.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in data memory; word index >= MEM_DEPTH is an access fault.
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock; memory writes occur on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword used for SB/SH.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3, or index >= MEM_DEPTH.
- mem_we  out  1  to memory WE.
- mem_a  out  32  to memory A; always word-aligned ({addr[31:2],2'b00}).
- mem_wd  out  32  to memory WD.
- mem_rd  in  32  from memory RD (combinational read).

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_we=0, mem_a=0, mem_wd=0. All latched request registers cleared.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - Error detection:
    - illegal funct3: load 3/6/7, store >2;
    - halfword with addr[0]=1;
    - word with addr[1:0]!=0;
    - addr[31:2] >= MEM_DEPTH.
  - Error -> RESP with err=1. Otherwise -> ACCESS.
- ACCESS:
  - mem_a = aligned latched addr.
  - Load: capture mem_rd, select lane by addr[1:0] (little-endian), sign/zero-extend, -> RESP.
  - SW: mem_we=1, mem_wd=wdata for this cycle only, -> RESP.
  - SB/SH: capture mem_rd, replace byte lane addr[1:0] or halfword lane addr[1], -> MERGE_WR.
- MERGE_WR: mem_we=1, mem_wd=merged word, mem_a unchanged, -> RESP.
- RESP: rsp_valid=1 for exactly one cycle with registered rdata/err, -> IDLE.
- No response back-pressure; a new request is only accepted in IDLE.
- Latency from accept edge to rsp_valid:
  - loads and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - errors: 1 cycle.
- mem_we is asserted in at most one cycle per request and never for errors. mem_we is 0 in IDLE and RESP.
- Reset mid-operation: FSM returns to IDLE immediately and mem_we drops combinationally. An RMW interrupted before MERGE_WR leaves memory unchanged, and no rsp_valid is issued.
- req_* inputs changing after acceptance have no effect.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (IDLE=0, ACCESS=1, MERGE_WR=2, RESP=3).
- One combinational sub-module, lsu_align, holds the lane extract/extend and lane merge logic. The FSM stays in lsu_ctrl.

Test Plan:
- Preload word index 4 (addr 0x10) = 0x8899AABB. LB 0x11 -> rdata 0xFFFFFFAA. LBU 0x13 -> 0x00000088. Each rsp_valid 2 cycles after accept, err=0.
- Same word: LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. LW 0x10 -> 0x8899AABB.
- SB 0x12 wdata 0x12345677 -> mem_we high exactly 1 cycle (MERGE_WR) with mem_wd 0x8877AABB. rsp_valid 3 cycles after accept; a following LW 0x10 returns 0x8877AABB.
- SH 0x11, then LW 0x12, then LB with funct3=3 -> each rsp_err=1, rdata=0, rsp 1 cycle after accept, mem_we never asserted.
- LW 0x1000 with MEM_DEPTH=1024 (index 1024) -> rsp_err=1, no memory activity. LW 0xFFC -> valid data, err=0.
- Start SB 0x10; drop rst during ACCESS -> req_ready=1 and mem_we=0 immediately, no rsp_valid. After release, LW 0x10 returns the unchanged word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values for memory
// accesses, the controller state encoding, and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Stores only come in B/H/W; loads add the unsigned B/H variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath for the LSU: extracts and extends load data from the
// memory word, and merges byte/halfword store data into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  lane_shift;

    assign lane_shift = {addr_lo, 3'b000};

    // Pick the addressed lane (little-endian) and sign/zero-extend it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        byte_sel  = rd_word[lane_shift +: 8];
        half_sel  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Overwrite only the addressed byte or halfword lane of the read word.
    always_comb begin
        merge_data = rd_word;
        case (funct3[1:0])
            2'd0:    merge_data[lane_shift +: 8] = wdata[7:0];
            2'd1:    merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, screens it
// for alignment/funct3/range faults, then drives the word-only memory port
// (direct write for SW, read-modify-write for SB/SH) and returns a one-cycle
// response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    localparam logic [XLEN-3:0] DEPTH_IDX = (XLEN-2)'(MEM_DEPTH);

    state_t          state;
    state_t          state_nxt;

    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] merge_q;

    logic            req_err;
    logic            is_rmw;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    // Sub-word stores need the old word first; word stores write directly.
    assign is_rmw = we_q && (funct3_q[1:0] != 2'd2);

    lsu_align u_align (
        .rd_word    (mem_rd),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Fault screening of the incoming request; any fault skips memory.
    always_comb begin
        req_err = 1'b0;
        if (!f3_legal(req_we, req_funct3)) begin
            req_err = 1'b1;
        end else if ((req_funct3[1:0] == 2'd1) && req_addr[0]) begin
            req_err = 1'b1;
        end else if ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
        if (req_addr[XLEN-1:2] >= DEPTH_IDX) begin
            req_err = 1'b1;
        end
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_err ? RESP : ACCESS;
                end
            end
            ACCESS:   state_nxt = is_rmw ? MERGE_WR : RESP;
            MERGE_WR: state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Moore outputs; memory writes only in ACCESS (SW) or MERGE_WR (SB/SH).
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_we    = 1'b0;
        mem_wd    = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            ACCESS: begin
                if (we_q && !is_rmw) begin
                    mem_we = 1'b1;
                    mem_wd = wdata_q;
                end
            end
            MERGE_WR: begin
                mem_we = 1'b1;
                mem_wd = merge_q;
            end
            RESP:    rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign mem_a     = {addr_q[XLEN-1:2], 2'b00};
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    // Request latch and data capture from the memory read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these are a handful of control/data flops, not a memory array, so all are reset to give clean outputs.
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= req_err;
                        rdata_q  <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                    end else if (is_rmw) begin
                        merge_q <= merge_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a behavioural word memory on the memory
// port, directed cases from the block's test plan, a reset-abort case, and
// randomized traffic compared against a byte-mask reference model.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int total = 0;
    int bad   = 0;

    lsu_ctrl #(.MEM_DEPTH(1024), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: combinational read, write on rising edge, random preload.
    assign mem_rd = mem[mem_a[11:2]];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[4] = 32'h8899AABB;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_a[11:2]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request, called at a falling edge with the DUT idle. Expectations
    // come from the reference memory and the access rules only.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        logic        legal, mis, oor, e_err;
        int          size, sh, e_lat, e_nwe, cyc, nwe;
        logic [31:0] w, v, mask, nw, wd_seen, a_seen, rd;
        logic        seen, er;

        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = int'(f3[1:0]);
        mis   = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
        oor   = (addr >> 2) >= 32'd1024;
        e_err = !legal || mis || oor;
        v     = 32'd0;
        nw    = 32'd0;
        e_nwe = 0;
        if (e_err) begin
            e_lat = 1;
        end else begin
            w  = ref_mem[addr[11:2]];
            sh = 8 * int'(addr[1:0]);
            if (!we) begin
                e_lat = 2;
                if (size == 0) begin
                    v = (w >> sh) & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
                end else if (size == 1) begin
                    v = (w >> sh) & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
                end else begin
                    v = w;
                end
            end else begin
                e_nwe = 1;
                e_lat = (size == 2) ? 2 : 3;
                mask  = (size == 0) ? (32'hFF << sh) :
                        (size == 1) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
                nw    = (w & ~mask) | ((wdata << sh) & mask);
                ref_mem[addr[11:2]] = nw;
            end
        end

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        cyc = 0; nwe = 0; seen = 1'b0; rd = 32'd0; er = 1'b0;
        wd_seen = 32'd0; a_seen = 32'd0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                nwe++;
                wd_seen = mem_wd;
                a_seen  = mem_a;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                rd   = rsp_rdata;
                er   = rsp_err;
            end
        end
        chk({tag, ".rsp_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, ".latency"}, cyc, e_lat);
        chk({tag, ".rdata"}, rd, v);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, e_err});
        chk({tag, ".we_cycles"}, nwe, e_nwe);
        if (we && !e_err) begin
            chk({tag, ".mem_wd"}, wd_seen, nw);
            chk({tag, ".mem_a"}, a_seen, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        chk({tag, ".pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic        quiet;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [2:0]  legal_ld [5];

        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        #1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

        repeat (2) @(negedge clk);
        chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'd0);
        chk("reset.rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset.mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset.mem_a", mem_a, 32'd0);
        chk("reset.mem_wd", mem_wd, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Lane selection and extension on the preloaded word.
        do_req(1'b0, 3'd0, 32'h11, 32'h0, "lb_11");
        do_req(1'b0, 3'd4, 32'h13, 32'h0, "lbu_13");
        do_req(1'b0, 3'd1, 32'h12, 32'h0, "lh_12");
        do_req(1'b0, 3'd5, 32'h10, 32'h0, "lhu_10");
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
        chk("lb_11.literal", rsp_rdata, 32'h0);
        // Read-modify-write byte store and read-back.
        do_req(1'b1, 3'd0, 32'h12, 32'h12345677, "sb_12");
        chk("sb_12.ref_word", ref_mem[4], 32'h8877AABB);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_sb");
        // Faults: misaligned, illegal funct3, out of range, last word.
        do_req(1'b1, 3'd1, 32'h11, 32'hDEADBEEF, "sh_mis");
        do_req(1'b0, 3'd2, 32'h12, 32'h0, "lw_mis");
        do_req(1'b0, 3'd3, 32'h10, 32'h0, "ld_f3_3");
        do_req(1'b1, 3'd4, 32'h10, 32'h0, "st_f3_4");
        do_req(1'b0, 3'd2, 32'h1000, 32'h0, "lw_oor");
        do_req(1'b0, 3'd2, 32'hFFC, 32'h0, "lw_last");
        do_req(1'b1, 3'd1, 32'h22, 32'hCAFEF00D, "sh_22");
        do_req(1'b0, 3'd2, 32'h20, 32'h0, "lw_20");

        // Reset during the ACCESS cycle of a byte store aborts it cleanly.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'h000000EE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("abort.req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort.mem_we", {31'd0, mem_we}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || mem_we) quiet = 1'b0;
            if (i == 1) rst = 1'b1;
        end
        chk("abort.quiet", {31'd0, quiet}, 32'd1);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_abort");

        // Randomized traffic over a small window plus the range boundary.
        for (int n = 0; n < 200; n++) begin
            r_we = 1'($urandom);
            if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom);
            else if (r_we)                  r_f3 = 3'($urandom_range(0, 2));
            else                            r_f3 = legal_ld[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0)
                r_addr = {20'd0, 10'd0, 2'($urandom)} + 32'(($urandom_range(1020, 1030)) << 2);
            else
                r_addr = 32'($urandom_range(0, 63));
            do_req(r_we, r_f3, r_addr, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
